// File: rtl/uart_pwm_cmd_ctrl.sv
// uart_pwm_cmd_ctrl: turns 3-byte UART command frames {header|ch, duty, xor}
// into a valid/ready configuration request toward a PWM core, keeps a shadow
// copy of every channel's duty, and counts framing errors (bad checksum,
// inter-byte timeout, bytes arriving while a request is still pending).
module uart_pwm_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 27000,
  parameter logic [3:0]  HEADER_NIB     = 4'hA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic [23:0] uart_rx_bytes,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic [1:0]  cfg_ch,
  output logic [7:0]  cfg_duty,
  output logic [31:0] duty_all,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic        busy
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_DUTY = 2'd1,
    GET_CHK  = 2'd2,
    ISSUE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    ch_q, ch_d;
  logic [7:0]    duty_q, duty_d;
  logic [23:0]   rx_bytes_q, rx_bytes_d;
  logic          cfg_valid_q, cfg_valid_d;
  logic [1:0]    cfg_ch_q, cfg_ch_d;
  logic [7:0]    cfg_duty_q, cfg_duty_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    err_count_q, err_count_d;

  logic          err_event;
  logic          header_ok;
  logic          tmo_expired;
  logic          handshake;
  logic [7:0]    expected_chk;

  assign header_ok    = (uart_rx_data[7:4] == HEADER_NIB) && (uart_rx_data[3:2] == 2'b00);
  assign tmo_expired  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign handshake    = cfg_valid_q && cfg_ready;
  // B0 is fully determined by the header nibble and the latched channel.
  assign expected_chk = {HEADER_NIB, 2'b00, ch_q} ^ duty_q;

  // Frame-parsing FSM: next state, byte capture, timeout and request handling.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    ch_d        = ch_q;
    duty_d      = duty_q;
    rx_bytes_d  = rx_bytes_q;
    cfg_valid_d = cfg_valid_q;
    cfg_ch_d    = cfg_ch_q;
    cfg_duty_d  = cfg_duty_q;
    err_event   = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        // Anything that is not a well-formed header is line noise: drop quietly.
        if (uart_rx_valid && header_ok) begin
          ch_d       = uart_rx_data[1:0];
          rx_bytes_d = {rx_bytes_q[15:0], uart_rx_data};
          state_d    = GET_DUTY;
        end
      end

      GET_DUTY: begin
        // A byte arriving on the expiry cycle still wins over the timeout.
        if (uart_rx_valid) begin
          duty_d     = uart_rx_data;
          rx_bytes_d = {rx_bytes_q[15:0], uart_rx_data};
          tmo_d      = '0;
          state_d    = GET_CHK;
        end else if (tmo_expired) begin
          tmo_d     = '0;
          err_event = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      GET_CHK: begin
        if (uart_rx_valid) begin
          rx_bytes_d = {rx_bytes_q[15:0], uart_rx_data};
          tmo_d      = '0;
          if (uart_rx_data == expected_chk) begin
            cfg_valid_d = 1'b1;
            cfg_ch_d    = ch_q;
            cfg_duty_d  = duty_q;
            state_d     = ISSUE;
          end else begin
            err_event = 1'b1;
            state_d   = IDLE;
          end
        end else if (tmo_expired) begin
          tmo_d     = '0;
          err_event = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ISSUE: begin
        // No timeout here: the request is held until the PWM core takes it.
        tmo_d = '0;
        if (uart_rx_valid) begin
          err_event = 1'b1;
        end
        if (handshake) begin
          cfg_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        tmo_d       = '0;
        cfg_valid_d = 1'b0;
      end
    endcase
  end

  // Error pulse and saturating error counter.
  always_comb begin
    frame_err_d = err_event;
    err_count_d = err_count_q;
    if (err_event && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // State register for the parser and request path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      ch_q        <= '0;
      duty_q      <= '0;
      rx_bytes_q  <= '0;
      cfg_valid_q <= 1'b0;
      cfg_ch_q    <= '0;
      cfg_duty_q  <= '0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      ch_q        <= ch_d;
      duty_q      <= duty_d;
      rx_bytes_q  <= rx_bytes_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_ch_q    <= cfg_ch_d;
      cfg_duty_q  <= cfg_duty_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  // One shadow duty lane per channel, written on the accepting handshake.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_q;

    // Capture the issued duty when this lane is the handshake target.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q <= '0;
      end else if (handshake && (cfg_ch_q == 2'(gi))) begin
        lane_q <= cfg_duty_q;
      end
    end

    assign duty_all[gi*8 +: 8] = lane_q;
  end

  assign uart_rx_bytes = rx_bytes_q;
  assign cfg_valid     = cfg_valid_q;
  assign cfg_ch        = cfg_ch_q;
  assign cfg_duty      = cfg_duty_q;
  assign frame_err     = frame_err_q;
  assign err_count     = err_count_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/uart_pwm_cmd_ctrl.md
UART_PWM_CMD_CTRL -- requirements
Module: uart_pwm_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 27000, max idle clocks between bytes of one frame.
REQ-002 SHALL have parameter HEADER_NIB, default 4'hA, required upper nibble of byte 0.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port uart_rx_valid  input  1  one-cycle strobe, uart_rx_data holds a received byte.
REQ-006 SHALL have port uart_rx_data  input  8  received byte, sampled only when uart_rx_valid=1.
REQ-007 SHALL have port uart_rx_bytes  output  24  last three accepted bytes, newest in [7:0].
REQ-008 SHALL have port cfg_valid  output  1  PWM config request pending.
REQ-009 SHALL have port cfg_ready  input  1  PWM core accepts config this cycle.
REQ-010 SHALL have port cfg_ch  output  2  target channel, stable while cfg_valid=1.
REQ-011 SHALL have port cfg_duty  output  8  duty value, stable while cfg_valid=1.
REQ-012 SHALL have port duty_all  output  32  shadow duty of ch3..ch0, ch0 in [7:0].
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on any frame error.
REQ-014 SHALL have port err_count  output  8  saturating frame error count.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 Frame SHALL be 3 bytes: B0={HEADER_NIB,2'b00,ch[1:0]}, B1=duty, B2=B0^B1.
REQ-017 FSM states SHALL be IDLE, GET_DUTY, GET_CHK, ISSUE.
REQ-018 IDLE: on valid with B0[7:4]=HEADER_NIB and B0[3:2]=0, SHALL latch ch and go to GET_DUTY next cycle; other bytes discarded silently, no error, no uart_rx_bytes update.
REQ-019 GET_DUTY: on valid SHALL latch duty, go to GET_CHK.
REQ-020 GET_CHK: on valid with B2 equal to B0^B1 SHALL go to ISSUE with cfg_valid=1 the following cycle; on mismatch SHALL go to IDLE and pulse frame_err.
REQ-021 uart_rx_bytes SHALL shift {uart_rx_bytes[15:0],data} on every byte accepted in IDLE (header ok), GET_DUTY or GET_CHK.
REQ-022 Timeout counter SHALL clear on every accepted byte and count in GET_DUTY/GET_CHK; reaching TIMEOUT_CYCLES-1 with no valid SHALL force IDLE and pulse frame_err.
REQ-023 uart_rx_valid in the same cycle as timeout expiry SHALL take priority; byte accepted, no error.
REQ-024 ISSUE: cfg_valid, cfg_ch, cfg_duty SHALL hold until cfg_valid&cfg_ready; on that edge duty_all[ch*8+:8]<=cfg_duty and FSM returns to IDLE, cfg_valid=0 next cycle.
REQ-025 ISSUE SHALL not time out; cfg_valid SHALL never deassert without handshake.
REQ-026 Any uart_rx_valid in ISSUE SHALL be discarded and pulse frame_err (overrun), even if cfg_ready is high that cycle.
REQ-027 frame_err SHALL be asserted for exactly one cycle per error; err_count SHALL increment per pulse and saturate at 8'hFF.
REQ-028 Frame-to-config latency SHALL be 1 cycle: B2 valid at edge N -> cfg_valid=1 after edge N+1.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and clear uart_rx_bytes, cfg_valid, cfg_ch, cfg_duty, duty_all, frame_err, err_count, busy and timeout counter to 0, including mid-frame or mid-ISSUE.
REQ-030 After rst_n deassertion the first byte SHALL be treated as a B0 candidate.

Verification
REQ-031 Bytes A1,80,21 with cfg_ready=1 -> cfg_valid one cycle, cfg_ch=1, cfg_duty=80, duty_all=0000_8000, uart_rx_bytes=A18021, err_count=0.
REQ-032 Bytes A2,40,FF -> no cfg_valid, one frame_err pulse, err_count=1, state IDLE.
REQ-033 A0 then gap of TIMEOUT_CYCLES clocks, then 55,A0,10,B0 -> one frame_err from timeout, 55 ignored, cfg_ch=0 cfg_duty=10 issued.
REQ-034 A3,FF,5C with cfg_ready=0 for 20 cycles, byte 12 arriving meanwhile -> cfg_valid held stable 20 cycles, one overrun frame_err, duty_all[31:24]=FF after handshake.
REQ-035 rst_n pulsed low after A1,80 -> all outputs 0; following 80,21 ignored, no cfg_valid.
REQ-036 260 bad-checksum frames -> err_count=FF, no wrap.
